// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage : pipeline M stage - data memory request/response and M/W register
// Optional bus timeout guarded by MEM_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module memory_stage #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUoutM,
  input  logic [31:0] WriteDataM,
  input  logic [2:0]  funct3M,
  input  logic [4:0]  RdM,
  input  logic [31:0] inc_PCM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUoutW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  RdW,
  output logic [31:0] inc_PCW,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        reg_write_q, reg_write_d;
  logic [1:0]  result_src_q, result_src_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic [31:0] read_data_q, read_data_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] inc_pc_q, inc_pc_d;
  logic        misalign_q, misalign_d;

  logic        is_load, is_mem, misaligned, access;
  logic        req, stall, abort, mis_pulse;
  logic [31:0] lane, load_ext, st_wdata;
  logic [3:0]  st_be;

  assign is_load    = (ResultSrcM == 2'b01);
  assign is_mem     = is_load | MemWriteM;
  assign misaligned = is_mem && (((funct3M[1:0] == 2'b01) && ALUoutM[0]) ||
                                 ((funct3M[1:0] == 2'b10) && (ALUoutM[1:0] != 2'b00)));
  assign access     = is_mem && !misaligned;

  // Lane select by byte offset, then sign/zero extension by funct3
  assign lane = mem_rdata >> {ALUoutM[1:0], 3'b000};

  always_comb begin
    load_ext = mem_rdata;
    case (funct3M)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    st_be    = 4'hF;
    st_wdata = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ALUoutM[1:0];
        st_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {ALUoutM[1], 1'b0};
        st_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        st_be    = 4'hF;
        st_wdata = WriteDataM;
      end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    abort     = 1'b0;
    mis_pulse = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (access) begin
          req = 1'b1;
          if (!mem_ack) begin
            state_d = S_WAIT;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = 8'h00;
`endif
          end
        end else if (is_mem) begin
          mis_pulse = 1'b1;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (mem_ack) begin
          state_d = S_IDLE;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          req     = 1'b0;
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'h01;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    stall = req && !mem_ack;
  end

  // Stalled or aborted cycles push a bubble; data fields simply hold
  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = 2'b00;
    alu_out_d    = alu_out_q;
    read_data_d  = read_data_q;
    rd_d         = rd_q;
    inc_pc_d     = inc_pc_q;
    misalign_d   = mis_pulse;
    if (!stall && !abort) begin
      reg_write_d  = RegWriteM && !misaligned;
      result_src_d = ResultSrcM;
      alu_out_d    = ALUoutM;
      rd_d         = RdM;
      inc_pc_d     = inc_PCM;
      if (is_load && access) read_data_d = load_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      alu_out_q    <= 32'h0;
      read_data_q  <= 32'h0;
      rd_q         <= 5'h0;
      inc_pc_q     <= 32'h0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      alu_out_q    <= alu_out_d;
      read_data_q  <= read_data_d;
      rd_q         <= rd_d;
      inc_pc_q     <= inc_pc_d;
      misalign_q   <= misalign_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  assign timeout_d = timeout_q | abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign mem_req      = req && rst_n;
  assign StallM       = stall && rst_n;
  assign mem_we       = mem_req && MemWriteM;
  assign mem_addr     = {ALUoutM[31:2], 2'b00};
  assign mem_wdata    = st_wdata;
  assign mem_be       = (mem_req && MemWriteM) ? st_be : 4'h0;
  assign RegWriteW    = reg_write_q;
  assign ResultSrcW   = result_src_q;
  assign ALUoutW      = alu_out_q;
  assign ReadDataW    = read_data_q;
  assign RdW          = rd_q;
  assign inc_PCW      = inc_pc_q;
  assign misalign_err = misalign_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// tb_memory_stage : directed scoreboard bench for memory_stage.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        RegWriteM, MemWriteM, mem_ack;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUoutM, WriteDataM, inc_PCM, mem_rdata;
  logic [2:0]  funct3M;
  logic [4:0]  RdM;
  logic        mem_req, mem_we, StallM, RegWriteW, misalign_err, timeout_err;
  logic [31:0] mem_addr, mem_wdata, ALUoutW, ReadDataW, inc_PCW;
  logic [3:0]  mem_be;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  rs;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
  } exp_t;
  exp_t sb_q[$];

  memory_stage #(.TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUoutM(ALUoutM), .WriteDataM(WriteDataM), .funct3M(funct3M),
    .RdM(RdM), .inc_PCM(inc_PCM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUoutW(ALUoutW),
    .ReadDataW(ReadDataW), .RdW(RdW), .inc_PCW(inc_PCW),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] pc);
    RegWriteM  = rw;
    ResultSrcM = rs;
    MemWriteM  = mw;
    ALUoutM    = alu;
    WriteDataM = wd;
    funct3M    = f3;
    RdM        = rd;
    inc_PCM    = pc;
  endtask

  task automatic nop_in();
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 32'h0);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [1:0] rs, input logic [31:0] alu,
                          input logic [31:0] rdata, input logic [31:0] pc);
    exp_t e;
    e.rd = rd; e.rs = rs; e.alu = alu; e.rdata = rdata; e.pc = pc;
    sb_q.push_back(e);
  endtask

  // Single-cycle load with same-cycle ack; checks request and zero stall
  task automatic load_fast(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rdata,
                           input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] exp_data);
    drive(1'b1, 2'b01, 1'b0, addr, 32'h0, f3, rd, pc);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    #1;
    check("ld_req", {31'h0, mem_req}, 32'h1);
    check("ld_addr", mem_addr, {addr[31:2], 2'b00});
    check("ld_stall", {31'h0, StallM}, 32'h0);
    check("ld_be", {28'h0, mem_be}, 32'h0);
    push_exp(rd, 2'b01, addr, exp_data, pc);
    step();
    nop_in();
  endtask

  task automatic store_fast(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
    drive(1'b0, 2'b00, 1'b1, addr, wd, f3, 5'd0, 32'h0);
    mem_ack = 1'b1;
    #1;
    check("st_req", {31'h0, mem_req}, 32'h1);
    check("st_we", {31'h0, mem_we}, 32'h1);
    check("st_be", {28'h0, mem_be}, {28'h0, exp_be});
    check("st_wdata", mem_wdata, exp_wd);
    check("st_stall", {31'h0, StallM}, 32'h0);
    step();
    nop_in();
  endtask

  // Scoreboard monitor: every retired writeback is matched against the queue
  always @(negedge clk) begin
    if (rst_n && RegWriteW) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got rd=%0d want none", RdW);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_rd", {27'h0, RdW}, {27'h0, e.rd});
        check("wb_rs", {30'h0, ResultSrcW}, {30'h0, e.rs});
        check("wb_alu", ALUoutW, e.alu);
        check("wb_pc", inc_PCW, e.pc);
        if (e.rs == 2'b01) check("wb_rdata", ReadDataW, e.rdata);
      end
    end
  end

  initial begin
    nop_in();
    #1 rst_n = 1'b0;
    #1;
    check("rst_regwrite", {31'h0, RegWriteW}, 32'h0);
    check("rst_rsrc", {30'h0, ResultSrcW}, 32'h0);
    check("rst_rdata", ReadDataW, 32'h0);
    check("rst_mis", {31'h0, misalign_err}, 32'h0);
    check("rst_tmo", {31'h0, timeout_err}, 32'h0);
    check("rst_req", {31'h0, mem_req}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Non-memory op passes through with no request
    drive(1'b1, 2'b00, 1'b0, 32'h0000_0055, 32'h0, 3'b000, 5'd3, 32'h0000_0008);
    #1;
    check("alu_req", {31'h0, mem_req}, 32'h0);
    check("alu_stall", {31'h0, StallM}, 32'h0);
    push_exp(5'd3, 2'b00, 32'h0000_0055, 32'h0, 32'h0000_0008);
    step();
    nop_in();

    load_fast(32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 5'd5, 32'h0000_000C, 32'hDEAD_BEEF);
    load_fast(32'h0000_0102, 3'b101, 32'h8765_4321, 5'd6, 32'h0000_0010, 32'h0000_8765);
    load_fast(32'h0000_0100, 3'b001, 32'h0000_8001, 5'd7, 32'h0000_0014, 32'hFFFF_8001);
    load_fast(32'h0000_0101, 3'b100, 32'h0000_FF00, 5'd8, 32'h0000_0018, 32'h0000_00FF);

    // LB at 0x103 with ack arriving in the fourth cycle
    drive(1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'h0, 3'b000, 5'd9, 32'h0000_001C);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lb_stall", {31'h0, StallM}, 32'h1);
      check("lb_req", {31'h0, mem_req}, 32'h1);
      check("lb_addr", mem_addr, 32'h0000_0100);
      step();
      check("lb_bubble", {31'h0, RegWriteW}, 32'h0);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h8000_0000;
    #1;
    check("lb_ack_stall", {31'h0, StallM}, 32'h0);
    push_exp(5'd9, 2'b01, 32'h0000_0103, 32'hFFFF_FF80, 32'h0000_001C);
    step();
    nop_in();

    store_fast(32'h0000_0102, 3'b001, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    store_fast(32'h0000_0101, 3'b000, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
    store_fast(32'h0000_0200, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // Misaligned word load
    drive(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 3'b010, 5'd10, 32'h0000_0020);
    mem_ack = 1'b1;
    #1;
    check("mis_req", {31'h0, mem_req}, 32'h0);
    check("mis_stall", {31'h0, StallM}, 32'h0);
    step();
    nop_in();
    check("mis_pulse", {31'h0, misalign_err}, 32'h1);
    check("mis_regwrite", {31'h0, RegWriteW}, 32'h0);
    step();
    check("mis_pulse_end", {31'h0, misalign_err}, 32'h0);

    // Reset while waiting, then a stray ack
    drive(1'b1, 2'b01, 1'b0, 32'h0000_0300, 32'h0, 3'b010, 5'd11, 32'h0000_0024);
    #1;
    check("rw_stall0", {31'h0, StallM}, 32'h1);
    step();
    check("rw_wait_req", {31'h0, mem_req}, 32'h1);
    check("rw_wait_stall", {31'h0, StallM}, 32'h1);
    rst_n = 1'b0;
    nop_in();
    #1;
    check("rw_req", {31'h0, mem_req}, 32'h0);
    check("rw_stall", {31'h0, StallM}, 32'h0);
    check("rw_rdata", ReadDataW, 32'h0);
    check("rw_regwrite", {31'h0, RegWriteW}, 32'h0);
    step();
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    check("rw_ack_req", {31'h0, mem_req}, 32'h0);
    check("rw_ack_stall", {31'h0, StallM}, 32'h0);
    step();
    check("rw_post_rdata", ReadDataW, 32'h0);
    check("rw_post_regwrite", {31'h0, RegWriteW}, 32'h0);
    check("rw_post_tmo", {31'h0, timeout_err}, 32'h0);
    nop_in();

    step();
    step();
    check("sb_drained", sb_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: number of WAIT cycles without ack before abort (used only when MEM_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports RegWriteM (1), ResultSrcM (2), MemWriteM (1), ALUoutM (32), WriteDataM (32), funct3M (3), RdM (5), inc_PCM (32), all inputs: the E/M pipeline register contents.
REQ-005 SHALL have outputs mem_req (1), mem_we (1), mem_addr (32, word-aligned), mem_wdata (32), mem_be (4): the data memory request.
REQ-006 SHALL have inputs mem_ack (1) and mem_rdata (32): the data memory response.
REQ-007 SHALL have output StallM, 1: hazard-unit freeze request for stages F/D/E/M.
REQ-008 SHALL have outputs RegWriteW (1), ResultSrcW (2), ALUoutW (32), ReadDataW (32), RdW (5), inc_PCW (32): the M/W pipeline register.
REQ-009 SHALL have output misalign_err, 1: one-cycle pulse.
REQ-010 SHALL have output timeout_err, 1: sticky flag.

Function
REQ-011 SHALL treat an instruction as a load when ResultSrcM==2'b01, as a store when MemWriteM==1, and as a non-memory op otherwise.
REQ-012 SHALL implement FSM states IDLE and WAIT.
REQ-013 In IDLE, for an aligned load/store, SHALL assert mem_req combinationally with mem_addr={ALUoutM[31:2],2'b00} and mem_we=MemWriteM.
REQ-014 A same-cycle mem_ack SHALL complete the access with zero stall.
REQ-015 If no mem_ack arrives in that cycle, SHALL go to WAIT.
REQ-016 In WAIT, SHALL hold mem_req and all request fields stable until mem_ack, then return to IDLE.
REQ-017 StallM SHALL equal (access needed or state==WAIT) and not mem_ack.
REQ-018 Store byte-enables SHALL be: SB -> 1 bit at ALUoutM[1:0]; SH -> 2'b11 shifted by 2*ALUoutM[1]; SW -> 4'hF.
REQ-019 mem_wdata SHALL carry the byte/half replicated across all lanes.
REQ-020 mem_be SHALL be 4'h0 for loads.
REQ-021 Loads SHALL select the lane by ALUoutM[1:0] and then extend: LB (000) and LH (001) sign-extend; LW (010) passes the word; LBU (100) and LHU (101) zero-extend.
REQ-022 The extended load data SHALL be registered into ReadDataW on the ack edge.
REQ-023 A halfword access with ALUoutM[0]=1, or a word access with ALUoutM[1:0]!=0, is misaligned: SHALL issue no request and no stall, pulse misalign_err, and load RegWriteW=0.
REQ-024 The M/W register SHALL capture all M fields when StallM==0.
REQ-025 While StallM==1, the M/W register SHALL load a bubble (RegWriteW=0, ResultSrcW=0); the other W fields are don't-care.
REQ-026 Non-memory ops SHALL pass through in one cycle with mem_req=0.
REQ-027 Latency: load/store completion = 1 + number of WAIT cycles; W fields SHALL be valid one edge after completion.

Reset
REQ-028 On rst_n low, SHALL immediately set state=IDLE.
REQ-029 On rst_n low, SHALL immediately clear all W outputs, timeout_err and misalign_err to 0.
REQ-030 On rst_n low, mem_req SHALL be 0.
REQ-031 Reset during WAIT SHALL abandon the access, and any later mem_ack SHALL be ignored while in IDLE with no access pending.

Configuration
REQ-032 With MEM_TIMEOUT_EN defined, SHALL count WAIT cycles with an 8-bit counter cleared on entry to WAIT.
REQ-033 With MEM_TIMEOUT_EN defined, on reaching TIMEOUT_CYC SHALL drop mem_req, return to IDLE, release StallM, bubble W, and set timeout_err, which stays set until reset.
REQ-034 Without MEM_TIMEOUT_EN, SHALL have no counter, SHALL wait indefinitely, and timeout_err SHALL be tied 0.

Verification
REQ-035 LW at 0x100, mem_ack in the same cycle, rdata=0xDEADBEEF -> StallM never 1; next edge ReadDataW=0xDEADBEEF, RegWriteW=1.
REQ-036 LB at 0x103, ack after 3 cycles, rdata=0x80000000 -> StallM high 3 cycles, 3 bubbles; then ReadDataW=0xFFFFFF80.
REQ-037 SH at 0x102 with WriteDataM=0x1234ABCD -> mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1.
REQ-038 LW at 0x101 -> mem_req=0, misalign_err pulses 1 cycle, RegWriteW=0.
REQ-039 rst_n low in WAIT, then ack -> state IDLE, all outputs 0, no W update.
REQ-040 With MEM_TIMEOUT_EN, no ack for 255 cycles -> mem_req drops, StallM=0, timeout_err=1 until reset.
